// File: rtl/pll_lock_sequencer.sv
// Purpose : ADPLL acquisition sequencer: loop reset, 9-bit SAR coarse-band search, handoff to the loop filter, lock monitor.
// Latency : all outputs registered; one ref_clk from an input event to the resulting output change.
// Backpressure: none; measurements are paced by count_valid, with a per-window timeout into ERROR.
//
// Ports:
//   ref_clk, reset_bar         sole clock, async active-low reset
//   start, abort               begin acquisition (IDLE/LOCKED/ERROR only) / return to IDLE (wins over start)
//   count_untill, target_count measurement window (ref cycles) and desired DCO count per window
//   dco_count, count_valid     frequency-counter result and its one-cycle completion strobe
//   in_tolerance               loop-filter error inside tolerance
//   reset2, clk_count_start, coarse_code, cold_start_traditional, continue_traditional
//                              controls to adpll_controller
//   locked, busy, status       {relock sticky, timeout sticky, locked, state[2:0]}
//
// Build option: define PLL_LOCK_SEQ_AUTO_RELOCK_EN to restart the full search on loss of lock;
// otherwise loss of lock falls back to TRACK with the coarse code kept.
module pll_lock_sequencer #(
    parameter int CNT_W       = 15,
    parameter int LOCK_CYCLES = 64
) (
    input  logic             ref_clk,
    input  logic             reset_bar,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] count_untill,
    input  logic [CNT_W-1:0] target_count,
    input  logic [CNT_W-1:0] dco_count,
    input  logic             count_valid,
    input  logic             in_tolerance,
    output logic             reset2,
    output logic             clk_count_start,
    output logic [8:0]       coarse_code,
    output logic             cold_start_traditional,
    output logic             continue_traditional,
    output logic             locked,
    output logic             busy,
    output logic [5:0]       status
);

    // Timeout counter must hold 2*count_untill+16.
    localparam int TW = CNT_W + 2;
    localparam int LW = $clog2(LOCK_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOOP_RST = 3'd1,
        S_MEAS     = 3'd2,
        S_UPDATE   = 3'd3,
        S_HANDOFF  = 3'd4,
        S_TRACK    = 3'd5,
        S_LOCKED   = 3'd6,
        S_ERROR    = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       rst_cnt_q, rst_cnt_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [TW-1:0]    limit_q, limit_d;
    logic [CNT_W-1:0] meas_q, meas_d;
    logic [3:0]       bit_q, bit_d;
    logic [8:0]       code_q, code_d;
    logic [LW-1:0]    lock_cnt_q, lock_cnt_d;
    logic [1:0]       loss_cnt_q, loss_cnt_d;
    logic             timeout_q, timeout_d;
    logic             relock_q, relock_d;
    logic             loss_event;

    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        bit_d      = bit_q;
        meas_d     = meas_q;
        limit_d    = limit_q;
        timeout_d  = timeout_q;
        relock_d   = relock_q;
        loss_event = (state_q == S_LOCKED) && !in_tolerance && (loss_cnt_q == 2'd3);

        case (state_q)
            S_IDLE, S_ERROR: begin
                if (start) begin
                    state_d   = S_LOOP_RST;
                    timeout_d = 1'b0;
                    relock_d  = 1'b0;
                end
            end
            S_LOOP_RST: begin
                if (rst_cnt_q == 2'd3) state_d = S_MEAS;
            end
            S_MEAS: begin
                // A result arriving in the expiry cycle is still accepted.
                if (count_valid) begin
                    state_d = S_UPDATE;
                    meas_d  = dco_count;
                end else if (timer_q == limit_q - TW'(1)) begin
                    state_d   = S_ERROR;
                    timeout_d = 1'b1;
                end
            end
            S_UPDATE: begin
                // Too fast: drop the trial bit. Equality keeps it (largest code with count <= target).
                if (meas_q > target_count) code_d[bit_q] = 1'b0;
                if (bit_q == 4'd0) begin
                    state_d = S_HANDOFF;
                end else begin
                    bit_d         = bit_q - 4'd1;
                    code_d[bit_d] = 1'b1;
                    state_d       = S_MEAS;
                end
            end
            S_HANDOFF: state_d = S_TRACK;
            S_TRACK: begin
                if (in_tolerance && (lock_cnt_q == LW'(LOCK_CYCLES - 1))) state_d = S_LOCKED;
            end
            S_LOCKED: begin
                if (start) begin
                    state_d   = S_LOOP_RST;
                    timeout_d = 1'b0;
                    relock_d  = 1'b0;
                end else if (loss_event) begin
                    relock_d = 1'b1;
`ifdef PLL_LOCK_SEQ_AUTO_RELOCK_EN
                    state_d  = S_LOOP_RST;
`else
                    state_d  = S_TRACK;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over everything and leaves the sticky flags as they were.
        if (abort) begin
            state_d   = S_IDLE;
            timeout_d = timeout_q;
            relock_d  = relock_q;
            meas_d    = meas_q;
        end

        if (state_d == S_LOOP_RST && state_q != S_LOOP_RST) begin
            code_d = 9'h100;
            bit_d  = 4'd8;
        end
        if (state_d == S_MEAS && state_q != S_MEAS) begin
            limit_d = {1'b0, count_untill, 1'b0} + TW'(16);
        end
        if (state_d == S_IDLE) code_d = 9'h000;

        // Each counter only runs while its state persists, so any exit or re-entry clears it.
        rst_cnt_d  = (state_q == S_LOOP_RST && state_d == S_LOOP_RST) ? rst_cnt_q + 2'd1 : 2'd0;
        timer_d    = (state_q == S_MEAS && state_d == S_MEAS) ? timer_q + TW'(1) : '0;
        lock_cnt_d = (state_q == S_TRACK && state_d == S_TRACK && in_tolerance) ? lock_cnt_q + LW'(1) : '0;
        loss_cnt_d = (state_q == S_LOCKED && state_d == S_LOCKED && !in_tolerance) ? loss_cnt_q + 2'd1 : 2'd0;
    end

    always_ff @(posedge ref_clk or negedge reset_bar) begin
        if (!reset_bar) begin
            state_q                <= S_IDLE;
            rst_cnt_q              <= 2'd0;
            timer_q                <= '0;
            limit_q                <= '0;
            meas_q                 <= '0;
            bit_q                  <= 4'd0;
            code_q                 <= 9'h000;
            lock_cnt_q             <= '0;
            loss_cnt_q             <= 2'd0;
            timeout_q              <= 1'b0;
            relock_q               <= 1'b0;
            reset2                 <= 1'b0;
            clk_count_start        <= 1'b0;
            cold_start_traditional <= 1'b0;
            continue_traditional   <= 1'b0;
            locked                 <= 1'b0;
            busy                   <= 1'b0;
        end else begin
            state_q                <= state_d;
            rst_cnt_q              <= rst_cnt_d;
            timer_q                <= timer_d;
            limit_q                <= limit_d;
            meas_q                 <= meas_d;
            bit_q                  <= bit_d;
            code_q                 <= code_d;
            lock_cnt_q             <= lock_cnt_d;
            loss_cnt_q             <= loss_cnt_d;
            timeout_q              <= timeout_d;
            relock_q               <= relock_d;
            // Outputs are decoded from the next state so they change with the state register.
            reset2                 <= (state_d == S_LOOP_RST);
            clk_count_start        <= (state_d == S_MEAS) && (state_q != S_MEAS);
            cold_start_traditional <= (state_d == S_HANDOFF);
            continue_traditional   <= (state_d == S_TRACK) || (state_d == S_LOCKED);
            locked                 <= (state_d == S_LOCKED);
            busy                   <= !((state_d == S_IDLE) || (state_d == S_LOCKED) || (state_d == S_ERROR));
        end
    end

    assign coarse_code = code_q;
    assign status      = {relock_q, timeout_q, locked, state_q};

endmodule

// File: tb/tb_pll_lock_sequencer.sv
module tb_pll_lock_sequencer;

    localparam int CNT_W = 15;

    logic             ref_clk;
    logic             reset_bar;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] count_untill;
    logic [CNT_W-1:0] target_count;
    logic [CNT_W-1:0] dco_count;
    logic             count_valid;
    logic             in_tolerance;
    logic             reset2;
    logic             clk_count_start;
    logic [8:0]       coarse_code;
    logic             cold_start_traditional;
    logic             continue_traditional;
    logic             locked;
    logic             busy;
    logic [5:0]       status;

    // Counter stimulus: an automatic DCO model (count = 4*code, 100 cycles after each start pulse)
    // plus a manual override for hand-written corner cases.
    logic             auto_cv, man_cv, dco_en;
    logic [CNT_W-1:0] auto_cnt, man_cnt;
    int               cd;

    assign count_valid = auto_cv | man_cv;
    assign dco_count   = auto_cv ? auto_cnt : man_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [8:0] exp_q[$];

    typedef struct {
        int target;
        int exp_code;
    } vec_t;
    vec_t vecs[6];

    pll_lock_sequencer #(.CNT_W(CNT_W), .LOCK_CYCLES(64)) dut (
        .ref_clk                (ref_clk),
        .reset_bar              (reset_bar),
        .start                  (start),
        .abort                  (abort),
        .count_untill           (count_untill),
        .target_count           (target_count),
        .dco_count              (dco_count),
        .count_valid            (count_valid),
        .in_tolerance           (in_tolerance),
        .reset2                 (reset2),
        .clk_count_start        (clk_count_start),
        .coarse_code            (coarse_code),
        .cold_start_traditional (cold_start_traditional),
        .continue_traditional   (continue_traditional),
        .locked                 (locked),
        .busy                   (busy),
        .status                 (status)
    );

    initial begin
        ref_clk = 1'b0;
        forever #5 ref_clk = ~ref_clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        auto_cv  = 1'b0;
        auto_cnt = '0;
        cd       = 0;
        forever begin
            @(negedge ref_clk);
            auto_cv = 1'b0;
            if (!dco_en) cd = 0;
            if (cd > 0) begin
                cd = cd - 1;
                if (cd == 0) begin
                    auto_cv  = 1'b1;
                    auto_cnt = {4'b0000, coarse_code, 2'b00};
                end
            end
            if (clk_count_start && dco_en) cd = 100;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge ref_clk);
        start = 1'b0;
    endtask

    task automatic do_abort(input logic [5:0] exp_status);
        abort = 1'b1;
        @(negedge ref_clk);
        abort = 1'b0;
        chk("abort_status", status, exp_status);
        chk("abort_busy", busy, 0);
        chk("abort_code", coarse_code, 0);
    endtask

    task automatic wait_meas();
        int k = 0;
        while (!clk_count_start && k < 50) begin
            @(negedge ref_clk);
            k++;
        end
        chk("meas_entry", clk_count_start, 1);
    endtask

    // Full acquisition from start up to TRACK; final code checked through the scoreboard.
    task automatic run_search(input int target, input int exp_code);
        int  cycle = 1, pulses = 0, colds = 0, rst_hi = 0;
        int  first_meas = -1, last_p = 0, bad_space = 0, cold_cycle = -10;
        bit  done = 0;
        logic [8:0] e;
        target_count = CNT_W'(target);
        count_untill = CNT_W'(100);
        dco_en       = 1'b1;
        exp_q.push_back(9'(exp_code));
        pulse_start();
        chk("lrst_status", status, 6'b000001);
        while (!done && cycle < 3000) begin
            if (reset2) rst_hi++;
            if (clk_count_start) begin
                pulses++;
                if (pulses == 1) first_meas = cycle;
                else if (cycle - last_p != 102) bad_space++;
                last_p = cycle;
            end
            if (cold_start_traditional) begin
                colds++;
                cold_cycle = cycle;
                if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("final_code", coarse_code, e);
                end
            end
            if (continue_traditional) done = 1;
            else begin
                @(negedge ref_clk);
                cycle++;
            end
        end
        chk("search_done", done, 1);
        chk("reset2_cycles", rst_hi, 4);
        chk("first_meas_cycle", first_meas, 5);
        chk("meas_pulses", pulses, 9);
        chk("pulse_spacing_errs", bad_space, 0);
        chk("cold_pulses", colds, 1);
        chk("track_after_handoff", cycle, cold_cycle + 1);
        chk("track_status", status, 6'b000101);
        exp_q.delete();
    endtask

    initial begin
        logic early, drop;
        vecs[0] = '{3000, 511};
        vecs[1] = '{0,    0};
        vecs[2] = '{2044, 511};
        vecs[3] = '{4,    1};
        vecs[4] = '{1023, 255};
        vecs[5] = '{1000, 250};

        reset_bar    = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        count_untill = CNT_W'(100);
        target_count = CNT_W'(1000);
        in_tolerance = 1'b0;
        man_cv       = 1'b0;
        man_cnt      = '0;
        dco_en       = 1'b0;

        repeat (3) @(negedge ref_clk);
        chk("rst_reset2", reset2, 0);
        chk("rst_ccs", clk_count_start, 0);
        chk("rst_code", coarse_code, 0);
        chk("rst_cold", cold_start_traditional, 0);
        chk("rst_cont", continue_traditional, 0);
        chk("rst_locked", locked, 0);
        chk("rst_busy", busy, 0);
        chk("rst_status", status, 0);
        reset_bar = 1'b1;
        @(negedge ref_clk);
        chk("idle_status", status, 0);

        for (int i = 0; i < 6; i++) begin
            run_search(vecs[i].target, vecs[i].exp_code);
            if (i != 5) do_abort(6'b000000);
        end

        // start while tracking is ignored
        pulse_start();
        chk("start_in_track", status, 6'b000101);

        // lock qualification: 63 good, 1 bad, 64 good
        early = 1'b0;
        in_tolerance = 1'b1;
        for (int i = 0; i < 63; i++) begin
            @(negedge ref_clk);
            if (locked) early = 1'b1;
        end
        in_tolerance = 1'b0;
        @(negedge ref_clk);
        if (locked) early = 1'b1;
        in_tolerance = 1'b1;
        for (int i = 0; i < 63; i++) begin
            @(negedge ref_clk);
            if (locked) early = 1'b1;
        end
        chk("lock_not_early", early, 0);
        @(negedge ref_clk);
        chk("locked_rise", locked, 1);
        chk("locked_status", status, 6'b001110);
        chk("locked_cont", continue_traditional, 1);

        // loss of lock: 3 bad holds, 4 bad acts
        drop = 1'b0;
        in_tolerance = 1'b0;
        repeat (3) begin
            @(negedge ref_clk);
            if (!locked) drop = 1'b1;
        end
        in_tolerance = 1'b1;
        @(negedge ref_clk);
        if (!locked) drop = 1'b1;
        in_tolerance = 1'b0;
        repeat (3) begin
            @(negedge ref_clk);
            if (!locked) drop = 1'b1;
        end
        chk("loss3_hold", drop, 0);
        @(negedge ref_clk);
        chk("loss4_locked", locked, 0);
`ifdef PLL_LOCK_SEQ_AUTO_RELOCK_EN
        chk("loss4_status", status, 6'b100001);
        chk("loss4_reset2", reset2, 1);
        chk("loss4_code", coarse_code, 9'h100);
`else
        chk("loss4_status", status, 6'b100101);
        chk("loss4_code", coarse_code, 250);
        chk("loss4_cont", continue_traditional, 1);
`endif
        do_abort(6'b100000);

        // measurement timeout
        dco_en = 1'b0;
        count_untill = CNT_W'(100);
        pulse_start();
        wait_meas();
        begin
            int k = 0;
            while (status[2:0] != 3'd7 && k < 1000) begin
                @(negedge ref_clk);
                k++;
            end
            chk("timeout_cycles", k, 216);
        end
        chk("error_status", status, 6'b010111);
        chk("error_busy", busy, 0);
        chk("error_code_hold", coarse_code, 9'h100);
        chk("error_reset2", reset2, 0);
        run_search(1000, 250);
        do_abort(6'b000000);

        // result arriving in the expiry cycle wins over the timeout
        dco_en = 1'b0;
        target_count = CNT_W'(1000);
        pulse_start();
        wait_meas();
        repeat (215) @(negedge ref_clk);
        man_cv  = 1'b1;
        man_cnt = CNT_W'(32767);
        @(negedge ref_clk);
        man_cv = 1'b0;
        chk("expiry_cv_wins", status, 6'b000011);
        @(negedge ref_clk);
        chk("expiry_next_code", coarse_code, 9'h080);
        do_abort(6'b000000);

        // abort together with count_valid mid-measurement
        pulse_start();
        wait_meas();
        repeat (10) @(negedge ref_clk);
        abort  = 1'b1;
        man_cv = 1'b1;
        @(negedge ref_clk);
        abort  = 1'b0;
        man_cv = 1'b0;
        chk("abort_cv_status", status, 0);
        chk("abort_cv_busy", busy, 0);
        chk("abort_cv_code", coarse_code, 0);
        @(negedge ref_clk);
        chk("abort_cv_stay_idle", status, 0);

        // asynchronous reset mid-search
        dco_en = 1'b1;
        pulse_start();
        wait_meas();
        repeat (30) @(negedge ref_clk);
        chk("pre_reset_busy", busy, 1);
        #2 reset_bar = 1'b0;
        #1;
        chk("areset_outputs",
            {reset2, clk_count_start, coarse_code, cold_start_traditional,
             continue_traditional, locked, busy, status}, 0);
        @(negedge ref_clk);
        reset_bar = 1'b1;
        dco_en    = 1'b0;
        @(negedge ref_clk);
        chk("post_reset_idle", status, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
# pll_lock_sequencer

Top-level acquisition sequencer for the ADPLL. It resets the loop and runs a 9-bit successive-approximation coarse-band search using the reference/DCO frequency counter. It then hands control to the traditional loop filter and monitors lock, relocking if lock is lost. It sits beside `adpll_controller`, driving its `reset2`, `clk_count_start`, `cold_start_traditional`, `continue_traditional` and coarse-setting inputs in place of manual scan sequencing.

## Interface
- `CNT_W`, 15: width of frequency-counter words.
- `LOCK_CYCLES`, 64: consecutive in-tolerance `ref_clk` cycles required to declare lock.
- `ref_clk`  in  1  sole clock; all logic on rising edge.
- `reset_bar`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin acquisition; honoured only in IDLE, LOCKED or ERROR.
- `abort`  in  1  return to IDLE from any state; overrides `start`.
- `count_untill`  in  CNT_W  measurement window in ref cycles; sampled on MEAS entry.
- `target_count`  in  CNT_W  desired DCO count per window.
- `dco_count`  in  CNT_W  counter result; valid when `count_valid`.
- `count_valid`  in  1  one-cycle pulse: measurement complete.
- `in_tolerance`  in  1  loop-filter frequency/phase error inside tolerance.
- `reset2`  out  1  loop reset to controller.
- `clk_count_start`  out  1  one-cycle pulse starting a measurement.
- `coarse_code`  out  9  coarse DCO setting (binary).
- `cold_start_traditional`  out  1  one-cycle pulse at handoff.
- `continue_traditional`  out  1  high in TRACK and LOCKED.
- `locked`  out  1  high in LOCKED only.
- `busy`  out  1  high in any state except IDLE, LOCKED, ERROR.
- `status`  out  6  [2:0] state code, [3] locked, [4] timeout sticky, [5] relock sticky.

## Operation
- State codes: IDLE=0, LOOP_RST=1, MEAS=2, UPDATE=3, HANDOFF=4, TRACK=5, LOCKED=6, ERROR=7.
- IDLE: all outputs 0, `coarse_code`=0. On `start`: go to LOOP_RST and clear both sticky flags.
- LOOP_RST: `reset2`=1 for exactly 4 cycles. Load `coarse_code`=9'h100 and bit index 8. Then go to MEAS.
- MEAS: `clk_count_start`=1 on the first cycle only. Timeout counter (17-bit) runs against limit 2*`count_untill`+16.
  - `count_valid` → UPDATE, latching `dco_count`.
  - Counter reaches limit → ERROR, set timeout flag.
  - `count_valid` in the expiry cycle wins.
- UPDATE (1 cycle): if latched count > `target_count` (unsigned), clear the current bit. Equality keeps the bit.
  - Bit index 0 → HANDOFF.
  - Otherwise decrement the index, set the new bit, → MEAS.
- Net result: the largest code whose count ≤ target. 9 measurements always.
- HANDOFF (1 cycle): `cold_start_traditional`=1. `coarse_code` frozen. → TRACK.
- TRACK: lock counter increments each cycle `in_tolerance`=1 and clears on 0. Reaching LOCK_CYCLES → LOCKED.
- LOCKED: loss counter counts consecutive `in_tolerance`=0 cycles and clears on 1. Reaching 4 → loss-of-lock action (see Configuration).
- ERROR: outputs as IDLE except `status`. `coarse_code` holds its last value.
- `count_valid` outside MEAS is ignored. `start` in other states is ignored.
- `abort` in any state → IDLE next cycle, counters cleared, sticky flags kept.

## Timing
- Reset: state IDLE. Every output is 0, `status`=0.
- `start` at cycle 0 → LOOP_RST at cycle 1.
  - `reset2` is high for cycles 1–4.
  - MEAS and `clk_count_start` at cycle 5.
- `count_valid` at cycle t → UPDATE at t+1 → new `coarse_code` and MEAS at t+2. `clk_count_start` pulses at t+2.
- Last UPDATE → HANDOFF next cycle → TRACK the cycle after. `continue_traditional` rises with TRACK.
- `locked` rises the cycle after the LOCK_CYCLES-th consecutive in-tolerance sample.
- All outputs are registered. No combinational input-to-output paths.

## Configuration
- `PLL_LOCK_SEQ_AUTO_RELOCK_EN` defined: loss of lock → LOOP_RST.
  - Sets relock flag; full search restarts with no `start` needed.
- Not defined: loss of lock → TRACK.
  - `locked` drops and relock flag sets; `coarse_code` is kept and no re-search occurs.
  - Status[5] is still driven.

## Test plan
- DCO model count=4*code, `target_count`=1000, `count_untill`=100, `count_valid` 100 cycles after each start pulse → 9 `clk_count_start` pulses, final `coarse_code`=250, one `cold_start_traditional` pulse.
- Same setup, `target_count`=3000 (above max 2044) → `coarse_code`=511; `target_count`=0 → `coarse_code`=0.
- `count_valid` withheld, `count_untill`=100 → ERROR exactly 216 cycles after MEAS entry, `status`=6'b010111. A following `start` clears the flag and restarts.
- `in_tolerance` high 63 cycles, low 1, then high 64 → `locked` rises only after the second run.
- In LOCKED, `in_tolerance` low 3 cycles → stays locked; low 4 → with the macro, LOOP_RST and `reset2` pulse; without it, TRACK and `coarse_code` unchanged; status[5]=1 in both.
- `abort` asserted mid-MEAS together with `count_valid` → IDLE next cycle, no UPDATE, `busy`=0. `reset_bar` low mid-search → all outputs 0 immediately.
